// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit drain path.
// The PARITY state encoding is always reserved; it is only reachable with UART_TX_PARITY_EN.
package uart_tx_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int FRAME_BITS_NOPAR = 10;
  localparam int FRAME_BITS_PAR   = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT1  = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_START  = 3'd4,
    ST_DATA   = 3'd5,
    ST_PARITY = 3'd6,
    ST_STOP   = 3'd7
  } state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run_i is high and
// pulses bit_tick_o in the last cycle of each serial bit.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  input  logic run_i,
  output logic bit_tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = run_i && !restart_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from the TX FIFO (active-low RDB, two-cycle read latency) and serialises them.
// Define UART_TX_PARITY_EN to add the PARITY_ODD port and a parity bit after the data bits.
module uart_tx_fifo_drain
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  TXEN,
  input  logic [DATA_WIDTH-1:0] FIFO_DATA,
  input  logic                  FIFO_EMPTY,
  output logic                  RDB,
  output logic                  TX,
  output logic                  TX_BUSY,
  output logic                  TX_DONE
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                  PARITY_ODD
`endif
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  rdb_q, rdb_d;
  logic                  tx_q, tx_d;
  logic                  bit_tick;
  logic                  fetch_ok;
  logic                  timer_run;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  // FIFO_EMPTY only matters where this is consulted: IDLE and the end of STOP.
  assign fetch_ok  = TXEN && !FIFO_EMPTY;
  assign timer_run = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_bit_timer (
    .clk_i     (CLK),
    .rst_ni    (RESET),
    .restart_i (state_q == ST_WAIT2),
    .run_i     (timer_run),
    .bit_tick_o(bit_tick)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      rdb_q   <= 1'b1;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      rdb_q   <= rdb_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE:  if (fetch_ok) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT1;
      ST_WAIT1: state_d = ST_WAIT2;
      // Read data is valid now, two cycles after the strobe.
      ST_WAIT2: begin
        state_d = ST_START;
        shift_d = FIFO_DATA;
        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
        par_d   = (^FIFO_DATA) ^ PARITY_ODD;
`endif
      end
      ST_START: if (bit_tick) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
`endif
      ST_STOP:  if (bit_tick) state_d = fetch_ok ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // RDB and TX are registered, so they are derived from the upcoming state.
  always_comb begin
    rdb_d = (state_d != ST_FETCH);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
    TX_BUSY = (state_q != ST_IDLE);
    TX_DONE = (state_q == ST_STOP) && bit_tick;
  end

  assign RDB = rdb_q;
  assign TX  = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench for uart_tx_fifo_drain: a FIFO model feeds bytes, a line monitor decodes frames.
module tb_uart_tx_fifo_drain;
  import uart_tx_pkg::*;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = FRAME_BITS_PAR;
`else
  localparam int FB = FRAME_BITS_NOPAR;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       TXEN = 1'b0;
  logic [7:0] FIFO_DATA = 8'h00;
  logic       FIFO_EMPTY = 1'b1;
  logic       RDB, TX, TX_BUSY, TX_DONE;
`ifdef UART_TX_PARITY_EN
  logic       PARITY_ODD = 1'b0;
`endif

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .TXEN      (TXEN),
    .FIFO_DATA (FIFO_DATA),
    .FIFO_EMPTY(FIFO_EMPTY),
    .RDB       (RDB),
    .TX        (TX),
    .TX_BUSY   (TX_BUSY),
    .TX_DONE   (TX_DONE)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD(PARITY_ODD)
`endif
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // FIFO model: strobe sampled at edge n, word latched at n+1, FIFO_DATA valid after n+1.
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] stage = 8'h00;
  int pops = 0;
  int underflow = 0;

  initial forever begin
    @(posedge CLK);
    if (!RDB) begin
      if (fifo_q.size() == 0) underflow++;
      else begin
        stage <= fifo_q.pop_front();
        pops++;
      end
    end
    FIFO_DATA  <= stage;
    FIFO_EMPTY <= (fifo_q.size() == 0);
  end

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // Line monitor: sample mid-bit on the falling edge, compare decoded frames to the scoreboard.
  bit         mon_active = 0;
  int         mon_cnt = 0;
  int         frames_seen = 0;
  int         gap_cnt = 0;
  int         gap_hist[$];
  int         rdb_run = 0;
  logic [7:0] mon_byte = 8'h00;
  logic       mon_par = 1'b0;

  initial forever begin
    @(negedge CLK);
    if (!RESET) begin
      mon_active = 0;
      gap_cnt = 0;
      rdb_run = 0;
    end else begin
      if (!RDB) rdb_run++;
      else if (rdb_run > 0) begin
        chk("rdb_width", rdb_run, 1);
        rdb_run = 0;
      end
      if (!mon_active) begin
        if (TX == 1'b0) begin
          mon_active = 1;
          mon_cnt = 0;
          gap_hist.push_back(gap_cnt);
        end else begin
          gap_cnt++;
        end
      end else begin
        mon_cnt++;
      end
      if (mon_active) begin
        if (mon_cnt % CPB == CPB / 2) begin
          int b;
          b = mon_cnt / CPB;
          if (b == 0) chk("start_bit", TX, 0);
          else if (b <= 8) mon_byte[b-1] = TX;
          else if (b == FB - 1) chk("stop_bit", TX, 1);
          else mon_par = TX;
        end
        if (mon_cnt == FB * CPB - 1) begin
          chk("tx_done_last", TX_DONE, 1);
          if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
          else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("frame_byte", mon_byte, e);
`ifdef UART_TX_PARITY_EN
            chk("frame_parity", mon_par, (^e) ^ PARITY_ODD);
`endif
          end
          frames_seen++;
          mon_active = 0;
          gap_cnt = 0;
        end else if (TX_DONE) begin
          chk("tx_done_early", TX_DONE, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      tick(1);
      n++;
    end
    chk("frame_wait", (frames_seen >= target), 1);
  endtask

  task automatic wait_pos(input int pos, input int budget);
    int n;
    n = 0;
    while (!(mon_active && mon_cnt >= pos) && n < budget) begin
      tick(1);
      n++;
    end
    chk("pos_wait", (mon_active && mon_cnt >= pos), 1);
  endtask

  initial begin
    int base_f, base_p, bad, drops;
    bit seen_busy;

    // Reset state
    #2 RESET = 1'b0;
    tick(3);
    chk("rst_rdb", RDB, 1);
    chk("rst_tx", TX, 1);
    chk("rst_busy", TX_BUSY, 0);
    chk("rst_done", TX_DONE, 0);
    RESET = 1'b1;
    tick(2);

    // Empty FIFO with transmit enabled: nothing may move
    TXEN = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (RDB !== 1'b1 || TX !== 1'b1 || TX_BUSY !== 1'b0) bad++;
    end
    chk("empty_window", bad, 0);

    // Single byte 0xA5
    base_f = frames_seen;
    base_p = pops;
    push_byte(8'hA5);
    wait_frames(base_f + 1, 400);
    tick(5);
    chk("single_pops", pops - base_p, 1);
    chk("single_idle", TX_BUSY, 0);

    // Back-to-back 0x00, 0xFF, 0x3C
    base_f = frames_seen;
    base_p = pops;
    gap_hist.delete();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    seen_busy = 0;
    drops = 0;
    for (int i = 0; i < 800 && frames_seen < base_f + 3; i++) begin
      tick(1);
      if (seen_busy && !TX_BUSY) drops++;
      if (TX_BUSY) seen_busy = 1;
    end
    chk("b2b_frames", frames_seen - base_f, 3);
    chk("b2b_busy_drops", drops, 0);
    chk("b2b_gap2", (gap_hist.size() > 1) ? gap_hist[1] : -1, 3);
    chk("b2b_gap3", (gap_hist.size() > 2) ? gap_hist[2] : -1, 3);
    tick(50);
    chk("b2b_pops", pops - base_p, 3);
    chk("b2b_empty", FIFO_EMPTY, 1);
    chk("b2b_idle", TX_BUSY, 0);

    // TXEN dropped during data bits of frame 1 with two bytes queued
    base_f = frames_seen;
    base_p = pops;
    push_byte(8'h11);
    push_byte(8'h22);
    wait_pos(3 * CPB, 300);
    TXEN = 1'b0;
    wait_frames(base_f + 1, 300);
    tick(200);
    chk("txen_pops", pops - base_p, 1);
    chk("txen_idle", TX_BUSY, 0);
    chk("txen_rdb_held", RDB, 1);
    TXEN = 1'b1;
    tick(1);
    chk("txen_refetch", RDB, 0);
    wait_frames(base_f + 2, 300);
    chk("txen_pops2", pops - base_p, 2);

    // Reset during data bit 4, then the next queued byte goes out whole
    tick(5);
    base_f = frames_seen;
    push_byte(8'h5A);
    push_byte(8'h96);
    wait_pos(5 * CPB + 5, 300);
    RESET = 1'b0;
    #1;
    chk("arst_tx", TX, 1);
    chk("arst_rdb", RDB, 1);
    chk("arst_busy", TX_BUSY, 0);
    void'(exp_q.pop_front());
    tick(3);
    RESET = 1'b1;
    wait_frames(base_f + 1, 400);
    chk("arst_sb_drained", exp_q.size(), 0);

`ifdef UART_TX_PARITY_EN
    // Parity sense with data 0x07 (three ones)
    tick(5);
    base_f = frames_seen;
    PARITY_ODD = 1'b0;
    push_byte(8'h07);
    wait_frames(base_f + 1, 400);
    chk("parity_even", mon_par, 1);
    tick(5);
    PARITY_ODD = 1'b1;
    push_byte(8'h07);
    wait_frames(base_f + 2, 400);
    chk("parity_odd", mon_par, 0);
`endif

    tick(10);
    chk("fifo_underflow", underflow, 0);
    chk("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
